// File: rtl/axi_id_remap_table_if.sv
// Request/response bus between an upstream AXI port and the ID remap table.
// Signal names carry the table's point of view (_i into the table, _o out of it).
//   slave  : the remap table
//   master : the upstream/downstream side driving requests and responses
interface axi_id_remap_table_if #(
    parameter int unsigned InIdWidth  = 4,
    parameter int unsigned OutIdWidth = 2
);
    logic                  req_valid_i;
    logic [InIdWidth-1:0]  req_id_i;
    logic                  req_ready_o;
    logic [OutIdWidth-1:0] req_remap_id_o;

    logic                  resp_valid_i;
    logic                  resp_ready_i;
    logic [OutIdWidth-1:0] resp_id_i;
    logic                  resp_last_i;
    logic [InIdWidth-1:0]  resp_orig_id_o;

    modport slave (
        input  req_valid_i, req_id_i, resp_valid_i, resp_ready_i, resp_id_i, resp_last_i,
        output req_ready_o, req_remap_id_o, resp_orig_id_o
    );

    modport master (
        output req_valid_i, req_id_i, resp_valid_i, resp_ready_i, resp_id_i, resp_last_i,
        input  req_ready_o, req_remap_id_o, resp_orig_id_o
    );
endinterface

// File: rtl/axi_id_remap_table.sv
// AXI ID remap table: compresses wide upstream IDs onto a small set of slots.
// A request whose ID is already in flight reuses that slot (keeps same-ID
// ordering); otherwise the lowest free slot is taken. Last response beats
// retire one transaction from the slot named by the response ID.
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   bus (slave)       request/response handshake, remapped and restored IDs
//   full_o / empty_o  all slots / no slot in use
//   in_flight_cnt_o   total outstanding transactions over all slots
//   err_o             one-cycle pulse after a retire aimed at an idle slot
module axi_id_remap_table #(
    parameter int unsigned InIdWidth    = 4,
    parameter int unsigned OutIdWidth   = 2,
    parameter int unsigned MaxTxnsPerId = 4,
    parameter int unsigned CntWidth     = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    axi_id_remap_table_if.slave            bus,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [CntWidth+OutIdWidth-1:0] in_flight_cnt_o,
    output logic                           err_o
);
    localparam int unsigned NoSlots  = 2 ** OutIdWidth;
    localparam int unsigned SumWidth = CntWidth + OutIdWidth;

    typedef logic [OutIdWidth-1:0] slot_idx_t;

    logic [CntWidth-1:0]  cnt_q  [NoSlots];
    logic [CntWidth-1:0]  cnt_d  [NoSlots];
    logic [InIdWidth-1:0] orig_q [NoSlots];
    logic [InIdWidth-1:0] orig_d [NoSlots];
    logic                 err_q, err_d;

    logic [NoSlots-1:0] valid;
    logic               hit, free_found, ready;
    slot_idx_t          hit_idx, free_idx, sel_idx;
    logic               push, pop, pop_legal;

    always_comb begin
        for (int unsigned i = 0; i < NoSlots; i++) begin
            valid[i] = (cnt_q[i] != '0);
        end
    end

    // Lookup uses registered state only, so a slot freed this cycle cannot be
    // handed to a new ID until the following cycle.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NoSlots; i++) begin
            if (valid[i] && (orig_q[i] == bus.req_id_i)) begin
                hit     = 1'b1;
                hit_idx = slot_idx_t'(i);
            end
        end
        // Descending scan so the lowest free index wins.
        for (int i = int'(NoSlots) - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = slot_idx_t'(i);
            end
        end
        sel_idx = hit ? hit_idx : free_idx;
        ready   = hit ? (cnt_q[hit_idx] != CntWidth'(MaxTxnsPerId)) : free_found;
    end

    assign bus.req_ready_o    = ready;
    assign bus.req_remap_id_o = sel_idx;
    assign bus.resp_orig_id_o = orig_q[bus.resp_id_i];

    assign push      = bus.req_valid_i & ready;
    assign pop       = bus.resp_valid_i & bus.resp_ready_i & bus.resp_last_i;
    assign pop_legal = pop & valid[bus.resp_id_i];

    always_comb begin
        err_d = pop & ~valid[bus.resp_id_i];
        for (int unsigned i = 0; i < NoSlots; i++) begin
            cnt_d[i]  = cnt_q[i];
            orig_d[i] = orig_q[i];
            // Push and pop on the same slot cancel out.
            if ((push && (sel_idx == slot_idx_t'(i))) &&
                !(pop_legal && (bus.resp_id_i == slot_idx_t'(i)))) begin
                cnt_d[i] = cnt_q[i] + CntWidth'(1);
            end else if (!(push && (sel_idx == slot_idx_t'(i))) &&
                         (pop_legal && (bus.resp_id_i == slot_idx_t'(i)))) begin
                cnt_d[i] = cnt_q[i] - CntWidth'(1);
            end
            if (push && (sel_idx == slot_idx_t'(i))) begin
                orig_d[i] = bus.req_id_i;
            end
        end
    end

    always_comb begin
        in_flight_cnt_o = '0;
        for (int unsigned i = 0; i < NoSlots; i++) begin
            in_flight_cnt_o = in_flight_cnt_o + SumWidth'(cnt_q[i]);
        end
    end

    assign full_o  = &valid;
    assign empty_o = ~|valid;
    assign err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NoSlots; i++) begin
                cnt_q[i]  <= '0;
                orig_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NoSlots; i++) begin
                cnt_q[i]  <= cnt_d[i];
                orig_q[i] <= orig_d[i];
            end
            err_q <= err_d;
        end
    end
endmodule

// File: doc/axi_id_remap_table.md
AXI_ID_REMAP_TABLE -- requirements
Module: axi_id_remap_table

Interface
REQ-001 SHALL have parameter InIdWidth, default 4: width of the wide upstream AXI ID.
REQ-002 SHALL have parameter OutIdWidth, default 2: width of the remapped ID; the table holds NoSlots = 2**OutIdWidth slots.
REQ-003 SHALL have parameter MaxTxnsPerId, default 4: maximum outstanding transactions per slot.
REQ-004 SHALL have parameter CntWidth, default 3: per-slot counter width, able to hold MaxTxnsPerId.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 Port clk_i, input, 1: clock, rising edge.
REQ-007 Port rst_ni, input, 1: synchronous active-low reset.
REQ-008 Port req_valid_i, input, 1: upstream request (AW/AR) present.
REQ-009 Port req_id_i, input, InIdWidth: wide ID of the request.
REQ-010 Port req_ready_o, output, 1: table can accept the request.
REQ-011 Port req_remap_id_o, output, OutIdWidth: slot index assigned to the request.
REQ-012 Port resp_valid_i, input, 1: downstream response beat (B/R) present.
REQ-013 Port resp_ready_i, input, 1: upstream accepts the response beat.
REQ-014 Port resp_id_i, input, OutIdWidth: remapped ID carried by the response.
REQ-015 Port resp_last_i, input, 1: final beat of the response (tie high for B).
REQ-016 Port resp_orig_id_o, output, InIdWidth: restored wide ID for resp_id_i.
REQ-017 Port full_o, output, 1: all slots valid.
REQ-018 Port empty_o, output, 1: no slot valid.
REQ-019 Port in_flight_cnt_o, output, CntWidth+OutIdWidth: sum of all slot counters.
REQ-020 Port err_o, output, 1: one-cycle registered pulse on an illegal retire.

Function
REQ-021 Each slot SHALL hold a valid bit, orig_id (InIdWidth) and cnt (CntWidth); valid SHALL equal (cnt != 0).
REQ-022 Lookup: if a valid slot has orig_id == req_id_i, that slot SHALL be selected (same-ID ordering preserved); at most one slot can match.
REQ-023 Otherwise, the lowest-index invalid slot SHALL be selected.
REQ-024 req_ready_o SHALL be low when the matching slot has cnt == MaxTxnsPerId, or when there is no match and no free slot; high otherwise.
REQ-025 req_ready_o and req_remap_id_o SHALL be combinational from registered state and req_id_i only, never from req_valid_i.
REQ-026 Push on req_valid_i & req_ready_o: the selected slot's cnt SHALL increment and its orig_id SHALL load req_id_i, visible the next cycle.
REQ-027 resp_orig_id_o SHALL equal the orig_id of slot resp_id_i, combinationally, regardless of valid.
REQ-028 Pop on resp_valid_i & resp_ready_i & resp_last_i: slot resp_id_i cnt SHALL decrement; the slot is freed when cnt reaches 0, visible the next cycle.
REQ-029 Beats with resp_last_i low SHALL NOT change state.
REQ-030 Simultaneous push and pop to the same slot SHALL leave cnt unchanged and the slot valid.
REQ-031 A slot freed by a pop in cycle N SHALL NOT be allocatable to a different ID until cycle N+1.
REQ-032 A pop to a slot with cnt == 0 SHALL be ignored, and err_o SHALL pulse high in the following cycle.
REQ-033 Counters SHALL never wrap; pushes at MaxTxnsPerId are blocked per REQ-024.
REQ-034 full_o, empty_o and in_flight_cnt_o SHALL be combinational from registered state.

Reset
REQ-035 While rst_ni is low at a rising edge, all slots SHALL clear: cnt=0, orig_id=0, valid=0; err_o SHALL clear to 0.
REQ-036 After reset, req_ready_o SHALL be 1, req_remap_id_o 0, empty_o 1, full_o 0, in_flight_cnt_o 0, resp_orig_id_o 0.
REQ-037 Reset asserted mid-operation SHALL discard all outstanding entries, with no err_o pulse for them.

Verification
REQ-038 Push IDs 0x5, 0x9, 0x5 -> remap IDs 0, 1, 0; slot0 cnt=2; in_flight_cnt_o=3.
REQ-039 Push 4 distinct IDs 0x1..0x4 -> full_o=1; push 0x7 gives req_ready_o=0; push 0x2 gives ready=1 and remap 1.
REQ-040 Push ID 0xA four times -> fifth push of 0xA gives req_ready_o=0; one last-beat pop on slot 0 -> ready=1 next cycle.
REQ-041 Slot 0 holds cnt=1; in one cycle push 0x3 and pop (last) slot 0 -> 0x3 goes to slot 1; slot 0 is free the next cycle.
REQ-042 Non-last R beat on slot 1 -> no state change; last beat -> cnt decrements; pop on an empty slot 2 -> err_o=1 for exactly one cycle.
REQ-043 Three entries outstanding, rst_ni low for one edge -> empty_o=1, in_flight_cnt_o=0, req_ready_o=1, err_o=0.
